// File: rtl/lsu_bus_ctrl.sv
// Load/store sequencer between the core and an 8-bit data memory on a shared tri-state bus.
// Define LSU_STORE_FWD_EN to add a one-entry last-store buffer that completes matching loads without the bus.
module lsu_bus_ctrl #(
  parameter int AW     = 4,
  parameter int DW     = 8,
  parameter int DEPTH  = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  output logic          ready,
  input  logic          is_store,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_oe,
  inout  wire  [DW-1:0] mem_data
);

  typedef enum logic [1:0] {IDLE, WR, RD, FIN} state_e;

  localparam logic [AW:0] DepthLim  = (AW+1)'(DEPTH);
  localparam logic [3:0]  RdCntInit = 4'(RD_LAT - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          outOfRange;

`ifdef LSU_STORE_FWD_EN
  logic          fwdValid_q, fwdValid_d;
  logic [AW-1:0] fwdAddr_q, fwdAddr_d;
  logic [DW-1:0] fwdData_q, fwdData_d;
  logic          fwdHit;

  assign fwdHit = fwdValid_q && (addr == fwdAddr_q);
`endif

  assign outOfRange = {1'b0, addr} >= DepthLim;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
`ifdef LSU_STORE_FWD_EN
    fwdValid_d = fwdValid_q;
    fwdAddr_d  = fwdAddr_q;
    fwdData_d  = fwdData_q;
`endif
    case (state_q)
      IDLE: begin
        if (req && ready) begin
          err_d = 1'b0;
          // maddr_q only moves for real bus accesses so mem_addr never glitches on errors or hits
          if (outOfRange) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else if (is_store) begin
            maddr_d = addr;
            wdata_d = wdata;
            state_d = WR;
          end
`ifdef LSU_STORE_FWD_EN
          else if (fwdHit) begin
            rdata_d = fwdData_q;
            state_d = FIN;
          end
`endif
          else begin
            maddr_d = addr;
            cnt_d   = RdCntInit;
            state_d = RD;
          end
        end
      end
      WR: begin
`ifdef LSU_STORE_FWD_EN
        fwdValid_d = 1'b1;
        fwdAddr_d  = maddr_q;
        fwdData_d  = wdata_q;
`endif
        state_d = FIN;
      end
      RD: begin
        if (cnt_q == 4'd0) begin
          rdata_d = mem_data;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      FIN: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      maddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      // a load cut short by reset keeps the previously returned data
      if (state_q != RD) rdata_q <= '0;
`ifdef LSU_STORE_FWD_EN
      fwdValid_q <= 1'b0;
      fwdAddr_q  <= '0;
      fwdData_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef LSU_STORE_FWD_EN
      fwdValid_q <= fwdValid_d;
      fwdAddr_q  <= fwdAddr_d;
      fwdData_q  <= fwdData_d;
`endif
    end
  end

  assign ready    = (state_q == IDLE) && !rst;
  assign done     = (state_q == FIN) && !rst;
  assign err      = done && err_q;
  assign rdata    = rdata_q;
  assign mem_addr = maddr_q;
  assign mem_we   = (state_q == WR) && !rst;
  assign mem_oe   = (state_q == RD) && !rst;
  assign mem_data = mem_we ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: directed table, reset-abort sequences and random traffic
// checked against a transaction-level model of memory, rdata and the optional store buffer.
module tb_lsu_bus_ctrl;

  localparam int AW     = 4;
  localparam int DW     = 8;
  localparam int DEPTH  = 8;
  localparam int RD_LAT = 3;
`ifdef LSU_STORE_FWD_EN
  localparam bit FwdOn = 1'b1;
`else
  localparam bit FwdOn = 1'b0;
`endif
  localparam int HitLat = FwdOn ? 1 : RD_LAT + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          is_store = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          ready, done, err, mem_we, mem_oe;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;

  logic [DW-1:0] memArr [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};

  int assertCount = 0;
  int failCount   = 0;

  logic [DW-1:0] refMem [8];
  logic [DW-1:0] refRdata;
  bit            refFwdValid;
  logic [AW-1:0] refFwdAddr;
  logic [DW-1:0] refFwdData;

  typedef struct {
    bit            isStore;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            expLat;
    bit            expErr;
    logic [DW-1:0] expRdata;
  } vec_t;

  vec_t vecs [12];
  vec_t v;

  always #5 clk = ~clk;

  lsu_bus_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .ready    (ready),
    .is_store (is_store),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .done     (done),
    .err      (err),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_oe   (mem_oe),
    .mem_data (mem_data)
  );

  // memory device on the far end of the shared bus
  assign mem_data = mem_oe ? memArr[mem_addr[2:0]] : {DW{1'bz}};

  always @(posedge clk) begin
    if (mem_we) memArr[mem_addr[2:0]] <= mem_data;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetFor(input int n);
    rst = 1'b1;
    req = 1'b1;
    is_store = 1'b1;
    addr = 4'd1;
    wdata = 8'hFF;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      checkOutput("rstDone", 32'(done), 0);
      checkOutput("rstErr", 32'(err), 0);
      checkOutput("rstWe", 32'(mem_we), 0);
      checkOutput("rstOe", 32'(mem_oe), 0);
      checkOutput("rstReady", 32'(ready), 0);
      if (i > 0) checkOutput("rstRdata", 32'(rdata), 0);
    end
    req = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("readyAfterReset", 32'(ready), 1);
    refRdata    = '0;
    refFwdValid = 1'b0;
  endtask

  // transaction-level reference: what each request must do, independent of how it is sequenced
  task automatic predict(input bit st, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int lat, output bit e, output logic [DW-1:0] rd,
                         output int oe, output int we);
    lat = 0; e = 1'b0; oe = 0; we = 0;
    if (int'(a) >= DEPTH) begin
      lat = 1;
      e = 1'b1;
    end else if (st) begin
      lat = 2;
      we = 1;
      refMem[a[2:0]] = d;
      if (FwdOn) begin
        refFwdValid = 1'b1;
        refFwdAddr  = a;
        refFwdData  = d;
      end
    end else if (FwdOn && refFwdValid && refFwdAddr == a) begin
      lat = 1;
      refRdata = refFwdData;
    end else begin
      lat = RD_LAT + 1;
      oe = RD_LAT;
      refRdata = refMem[a[2:0]];
    end
    rd = refRdata;
  endtask

  task automatic doOp(input bit st, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int lat, output bit e, output logic [DW-1:0] rd,
                      output int oe, output int we);
    checkOutput("readyBeforeAccept", 32'(ready), 1);
    req = 1'b1;
    is_store = st;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0;
    is_store = 1'($urandom);
    addr = 4'($urandom);
    wdata = 8'($urandom);
    lat = -1; e = 1'b0; rd = '0; oe = 0; we = 0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      checkOutput("weOeExclusive", 32'(mem_we & mem_oe), 0);
      checkOutput("errWithoutDone", 32'(err & ~done), 0);
      if (mem_we) begin
        we++;
        checkOutput("wrAddr", 32'(mem_addr), 32'(a));
        checkOutput("wrData", 32'(mem_data), 32'(d));
      end
      if (mem_oe) begin
        oe++;
        checkOutput("rdAddr", 32'(mem_addr), 32'(a));
        checkOutput("rdBus", 32'(mem_data), 32'(refMem[a[2:0]]));
      end
      if (done) begin
        lat = c;
        e = err;
        rd = rdata;
      end
    end
    if (lat < 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL doneTimeout: got no done in 40 cycles, expected one");
    end
    @(negedge clk);
    checkOutput("readyAfterDone", 32'(ready), 1);
  endtask

  task automatic applyStimulus(input vec_t sv, input bit fromTable);
    int mLat, mOe, mWe, aLat, aOe, aWe;
    bit mErr, aErr;
    logic [DW-1:0] mRd, aRd;
    predict(sv.isStore, sv.addr, sv.data, mLat, mErr, mRd, mOe, mWe);
    doOp(sv.isStore, sv.addr, sv.data, aLat, aErr, aRd, aOe, aWe);
    if (fromTable) begin
      mLat = sv.expLat;
      mErr = sv.expErr;
      mRd  = sv.expRdata;
    end
    checkOutput("latency", aLat, mLat);
    checkOutput("err", 32'(aErr), 32'(mErr));
    checkOutput("rdata", 32'(aRd), 32'(mRd));
    checkOutput("oeCycles", aOe, mOe);
    checkOutput("weCycles", aWe, mWe);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) refMem[i] = 8'h10 + 8'(i);
    refRdata    = '0;
    refFwdValid = 1'b0;
    refFwdAddr  = '0;
    refFwdData  = '0;

    vecs[0]  = '{1'b1, 4'd3,  8'hA5, 2,          1'b0, 8'h00};
    vecs[1]  = '{1'b0, 4'd3,  8'h00, HitLat,     1'b0, 8'hA5};
    vecs[2]  = '{1'b0, 4'd9,  8'h00, 1,          1'b1, 8'hA5};
    vecs[3]  = '{1'b1, 4'd7,  8'h5A, 2,          1'b0, 8'hA5};
    vecs[4]  = '{1'b0, 4'd7,  8'h00, HitLat,     1'b0, 8'h5A};
    vecs[5]  = '{1'b1, 4'd15, 8'h77, 1,          1'b1, 8'h5A};
    vecs[6]  = '{1'b0, 4'd3,  8'h00, RD_LAT + 1, 1'b0, 8'hA5};
    vecs[7]  = '{1'b0, 4'd8,  8'h00, 1,          1'b1, 8'hA5};
    vecs[8]  = '{1'b1, 4'd5,  8'h3C, 2,          1'b0, 8'hA5};
    vecs[9]  = '{1'b0, 4'd5,  8'h00, HitLat,     1'b0, 8'h3C};
    vecs[10] = '{1'b0, 4'd6,  8'h00, RD_LAT + 1, 1'b0, 8'h16};
    vecs[11] = '{1'b0, 4'd0,  8'h00, RD_LAT + 1, 1'b0, 8'h10};

    resetFor(2);
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], 1'b1);

    // store aborted by reset in its WR cycle must not reach memory
    req = 1'b1; is_store = 1'b1; addr = 4'd2; wdata = 8'h11;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    checkOutput("abortWrInWr", 32'(mem_we), 1);
    rst = 1'b1;
    #1;
    checkOutput("abortWrWeGated", 32'(mem_we), 0);
    checkOutput("abortWrDone", 32'(done), 0);
    @(negedge clk);
    checkOutput("abortWrNoDone", 32'(done), 0);
    checkOutput("abortWrReadyLow", 32'(ready), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abortWrReady", 32'(ready), 1);
    checkOutput("abortWrNoDoneLater", 32'(done), 0);
    refRdata    = '0;
    refFwdValid = 1'b0;
    v = '{1'b0, 4'd2, 8'h00, RD_LAT + 1, 1'b0, 8'h12};
    applyStimulus(v, 1'b1);

    // load aborted by reset mid-read keeps the old rdata
    req = 1'b1; is_store = 1'b0; addr = 4'd4;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    checkOutput("abortRdOe", 32'(mem_oe), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abortRdDone", 32'(done), 0);
    @(negedge clk);
    checkOutput("abortRdNoDone", 32'(done), 0);
    checkOutput("abortRdRdataKept", 32'(rdata), 32'h12);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abortRdReady", 32'(ready), 1);
    refFwdValid = 1'b0;

    resetFor(2);

    for (int n = 0; n < 200; n++) begin
      v.isStore  = 1'($urandom_range(0, 1));
      v.addr     = 4'($urandom_range(0, 11));
      v.data     = 8'($urandom);
      v.expLat   = 0;
      v.expErr   = 1'b0;
      v.expRdata = '0;
      applyStimulus(v, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
